gp_register_file: RTL and testbench

GP_REGISTER_FILE -- requirements
Module: gp_register_file

---
 rtl/gp_register_file.sv | 117 +++++++++++
 tb/tb_gp_register_file.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gp_register_file.sv
// General-purpose 16-bit register file with x86-style byte lanes, two write ports, N read ports, load busy tracking.
// Latency: writes land on the next clk edge; reads are combinational (same-cycle forwarding when BYPASS=1).
// Backpressure: none on writes; a reservation is refused (o_reserve_ready=0) while its register is busy and not being cleared.
module gp_register_file #(
    parameter int NUM_REGISTERS  = 8,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYPASS         = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_we0,
    input  logic                             i_we1,
    input  logic [$clog2(NUM_REGISTERS)-1:0] i_write_id0,
    input  logic [$clog2(NUM_REGISTERS)-1:0] i_write_id1,
    input  logic                             i_write_byte0,
    input  logic                             i_write_byte1,
    input  logic [15:0]                      i_write_data0,
    input  logic [15:0]                      i_write_data1,
    input  logic [NUM_READ_PORTS*$clog2(NUM_REGISTERS)-1:0] i_read_id,
    input  logic [NUM_READ_PORTS-1:0]        i_read_byte,
    output logic [NUM_READ_PORTS*16-1:0]     o_read_data,
    input  logic                             i_reserve_valid,
    input  logic [$clog2(NUM_REGISTERS)-1:0] i_reserve_id,
    output logic                             o_reserve_ready,
    output logic [NUM_REGISTERS-1:0]         o_busy,
    output logic [NUM_REGISTERS*16-1:0]      o_registers
);

    localparam int IW = $clog2(NUM_REGISTERS);

    logic [15:0]              r_regs [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] r_busy;

    logic [15:0]              w_next [NUM_REGISTERS];
    logic [15:0]              w_src  [NUM_REGISTERS];
    logic [IW-1:0]            w_phys0;
    logic [IW-1:0]            w_phys1;
    logic [7:0]               w_lo0, w_hi0, w_lo1, w_hi1;
    logic [NUM_REGISTERS-1:0] w_clr;
    logic [NUM_REGISTERS-1:0] w_busy_next;
    logic [IW-1:0]            w_rid;
    logic [15:0]              w_rword;

    // Physical target register and per-lane data for each write port; a byte write only
    // reaches registers 0-3 (id[1:0]) and carries its byte on whichever lane id[2] picks.
    always_comb begin
        w_phys0 = i_write_id0;
        w_phys1 = i_write_id1;
        if (i_write_byte0) w_phys0 = {{(IW-2){1'b0}}, i_write_id0[1:0]};
        if (i_write_byte1) w_phys1 = {{(IW-2){1'b0}}, i_write_id1[1:0]};
        w_lo0 = i_write_data0[7:0];
        w_hi0 = i_write_byte0 ? i_write_data0[7:0] : i_write_data0[15:8];
        w_lo1 = i_write_data1[7:0];
        w_hi1 = i_write_byte1 ? i_write_data1[7:0] : i_write_data1[15:8];
    end

    // Post-edge value of every register, resolved per lane; port 1 is applied last so it wins lane conflicts.
    always_comb begin
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            w_next[r] = r_regs[r];
            if (i_we0 && (w_phys0 == IW'(r))) begin
                if (!i_write_byte0 || !i_write_id0[2]) w_next[r][7:0]  = w_lo0;
                if (!i_write_byte0 ||  i_write_id0[2]) w_next[r][15:8] = w_hi0;
            end
            if (i_we1 && (w_phys1 == IW'(r))) begin
                if (!i_write_byte1 || !i_write_id1[2]) w_next[r][7:0]  = w_lo1;
                if (!i_write_byte1 ||  i_write_id1[2]) w_next[r][15:8] = w_hi1;
            end
            w_src[r] = (BYPASS != 0) ? w_next[r] : r_regs[r];
        end
    end

    // Read ports: word reads return the whole register, byte reads the zero-extended lane.
    always_comb begin
        o_read_data = '0;
        w_rid       = '0;
        w_rword     = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_rid = i_read_id[p*IW +: IW];
            if (i_read_byte[p]) begin
                w_rword = w_src[{{(IW-2){1'b0}}, w_rid[1:0]}];
                o_read_data[p*16 +: 16] = {8'h00, (w_rid[2] ? w_rword[15:8] : w_rword[7:0])};
            end else begin
                o_read_data[p*16 +: 16] = w_src[w_rid];
            end
        end
    end

    // Busy tracking: a load return (port 1) clears its register, an accepted reservation sets it;
    // set is applied after clear so a same-cycle handoff leaves the register busy.
    always_comb begin
        w_clr = '0;
        if (i_we1) w_clr[w_phys1] = 1'b1;
        o_reserve_ready = i_reserve_valid &&
                          (!r_busy[i_reserve_id] || (i_we1 && (w_phys1 == i_reserve_id)));
        w_busy_next = r_busy & ~w_clr;
        if (o_reserve_ready) w_busy_next[i_reserve_id] = 1'b1;
    end

    // State update; reset overrides any same-cycle write or reservation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGISTERS; r++) r_regs[r] <= '0;
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGISTERS; r++) r_regs[r] <= w_next[r];
            r_busy <= w_busy_next;
        end
    end

    // Flatten stored state onto the debug/datapath outputs.
    always_comb begin
        o_busy = r_busy;
        for (int r = 0; r < NUM_REGISTERS; r++) o_registers[r*16 +: 16] = r_regs[r];
    end

endmodule

// File: tb/tb_gp_register_file.sv
// Directed bench for gp_register_file: one BYPASS=1 and one BYPASS=0 instance share stimulus.
// Inputs change 1ns after the rising edge; combinational outputs are sampled 2ns later, state after the next edge.
module tb_gp_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, wb0, wb1;
    logic [2:0]  wid0, wid1;
    logic [15:0] wd0, wd1;
    logic [5:0]  rid;
    logic [1:0]  rbyte;
    logic        rsv_vld;
    logic [2:0]  rsv_id;
    logic [31:0] rdat_b, rdat_n;
    logic        rsv_rdy_b, rsv_rdy_n;
    logic [7:0]  busy_b, busy_n;
    logic [127:0] regs_b, regs_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gp_register_file #(.NUM_REGISTERS(8), .NUM_READ_PORTS(2), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset),
        .i_we0(we0), .i_we1(we1), .i_write_id0(wid0), .i_write_id1(wid1),
        .i_write_byte0(wb0), .i_write_byte1(wb1), .i_write_data0(wd0), .i_write_data1(wd1),
        .i_read_id(rid), .i_read_byte(rbyte), .o_read_data(rdat_b),
        .i_reserve_valid(rsv_vld), .i_reserve_id(rsv_id), .o_reserve_ready(rsv_rdy_b),
        .o_busy(busy_b), .o_registers(regs_b)
    );

    gp_register_file #(.NUM_REGISTERS(8), .NUM_READ_PORTS(2), .BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset),
        .i_we0(we0), .i_we1(we1), .i_write_id0(wid0), .i_write_id1(wid1),
        .i_write_byte0(wb0), .i_write_byte1(wb1), .i_write_data0(wd0), .i_write_data1(wd1),
        .i_read_id(rid), .i_read_byte(rbyte), .o_read_data(rdat_n),
        .i_reserve_valid(rsv_vld), .i_reserve_id(rsv_id), .o_reserve_ready(rsv_rdy_n),
        .o_busy(busy_n), .o_registers(regs_n)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wb0 = 0; wb1 = 0; wid0 = 0; wid1 = 0; wd0 = 0; wd1 = 0;
        rsv_vld = 0; rsv_id = 0;
    endtask

    // Advance one clock; inputs may be changed on return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] reg_of(input logic [127:0] v, input int r);
        return v[r*16 +: 16];
    endfunction

    initial begin
        reset = 1; idle(); rid = 0; rbyte = 0;
        tick(); tick();
        reset = 0;
        #2;
        check("reset_regs", regs_b, 128'h0);
        check("reset_busy", busy_b, 8'h00);
        check("reset_rdy_idle", rsv_rdy_b, 1'b0);

        // Word write reg 2 = BEEF; bypass sees it now, the stored-only copy does not.
        we0 = 1; wid0 = 3'd2; wd0 = 16'hBEEF; rid = {3'd0, 3'd2}; rbyte = 2'b00;
        #2;
        check("byp_word_fwd", rdat_b[15:0], 16'hBEEF);
        check("nob_word_old", rdat_n[15:0], 16'h0000);
        tick();
        check("reg2_word", reg_of(regs_b, 2), 16'hBEEF);

        // Byte write id 6 (DH) with junk in the upper data byte.
        we0 = 1; wb0 = 1; wid0 = 3'd6; wd0 = 16'hAB12; rid = {3'd2, 3'd2}; rbyte = 2'b10;
        #2;
        check("byp_dh_merge", rdat_b[15:0], 16'h12EF);
        check("byp_dl_read", rdat_b[31:16], 16'h00EF);
        tick();
        idle(); rid = {3'd6, 3'd2}; rbyte = 2'b11;
        #2;
        check("reg2_byte", reg_of(regs_b, 2), 16'h12EF);
        check("dl_read", rdat_b[15:0], 16'h00EF);
        check("dh_read", rdat_b[31:16], 16'h0012);

        // Both ports word-write reg 1: port 1 wins, also on the bypass path.
        we0 = 1; wid0 = 3'd1; wd0 = 16'h1111; we1 = 1; wid1 = 3'd1; wd1 = 16'h2222;
        rid = {3'd0, 3'd1}; rbyte = 2'b00;
        #2;
        check("byp_p1_wins", rdat_b[15:0], 16'h2222);
        tick();
        check("reg1_p1_wins", reg_of(regs_b, 1), 16'h2222);

        // Disjoint lanes of reg 0 in one cycle: AL from port 0, AH from port 1.
        idle(); we0 = 1; wb0 = 1; wid0 = 3'd0; wd0 = 16'h00AA;
        we1 = 1; wb1 = 1; wid1 = 3'd4; wd1 = 16'h0055; rid = {3'd0, 3'd0}; rbyte = 2'b00;
        #2;
        check("byp_lane_merge", rdat_b[15:0], 16'h55AA);
        tick();
        check("reg0_lanes", reg_of(regs_b, 0), 16'h55AA);

        // Port 0 word vs port 1 low byte on reg 1: only the low lane goes to port 1.
        idle(); we0 = 1; wid0 = 3'd1; wd0 = 16'h4444; we1 = 1; wb1 = 1; wid1 = 3'd1; wd1 = 16'h0099;
        tick();
        check("reg1_lane_prio", reg_of(regs_b, 1), 16'h4499);

        // Reservation flow on reg 3.
        idle(); rsv_vld = 1; rsv_id = 3'd3;
        #2;
        check("rsv_first_rdy", rsv_rdy_b, 1'b1);
        tick();
        check("rsv_busy_set", busy_b, 8'h08);
        #1;
        check("rsv_again_rej", rsv_rdy_b, 1'b0);
        tick();
        check("rsv_rej_nochg", busy_b, 8'h08);
        we1 = 1; wid1 = 3'd3; wd1 = 16'hCAFE;
        #2;
        check("rsv_handoff_rdy", rsv_rdy_b, 1'b1);
        tick();
        check("rsv_handoff_busy", busy_b, 8'h08);
        check("reg3_load", reg_of(regs_b, 3), 16'hCAFE);

        // Byte load return into BH (id 7) clears reg 3's busy bit.
        idle(); we1 = 1; wb1 = 1; wid1 = 3'd7; wd1 = 16'h005A;
        tick();
        check("byte_clr_busy", busy_b, 8'h00);
        check("reg3_bh", reg_of(regs_b, 3), 16'h5AFE);

        // Reserve regs 2 and 3, then port 0 writes reg 3: busy untouched.
        idle(); rsv_vld = 1; rsv_id = 3'd2;
        tick();
        rsv_id = 3'd3;
        tick();
        check("busy_0c", busy_b, 8'h0C);
        idle(); we0 = 1; wid0 = 3'd3; wd0 = 16'h1234;
        tick();
        check("p0_keeps_busy", busy_b, 8'h0C);
        check("reg3_p0", reg_of(regs_b, 3), 16'h1234);

        // Port 1 to a non-busy register: data lands, busy stays clear there.
        idle(); we1 = 1; wid1 = 3'd5; wd1 = 16'h0505;
        tick();
        check("p1_nonbusy_busy", busy_b, 8'h0C);
        check("reg5_p1", reg_of(regs_b, 5), 16'h0505);

        // Reset beats a same-cycle write and reservation.
        idle(); reset = 1; we0 = 1; wid0 = 3'd2; wd0 = 16'hFFFF; rsv_vld = 1; rsv_id = 3'd4;
        tick();
        reset = 0; idle();
        #1;
        check("rst_regs_byp", regs_b, 128'h0);
        check("rst_regs_nob", regs_n, 128'h0);
        check("rst_busy", busy_b, 8'h00);

        // Stored-only instance sees a write one cycle late.
        we0 = 1; wid0 = 3'd5; wd0 = 16'h00FF; rid = {3'd5, 3'd5}; rbyte = 2'b00;
        #2;
        check("nob_same_cycle", rdat_n[15:0], 16'h0000);
        check("byp_same_cycle", rdat_b[31:16], 16'h00FF);
        tick();
        idle();
        #2;
        check("nob_next_cycle", rdat_n[15:0], 16'h00FF);
        check("nob_port1", rdat_n[31:16], 16'h00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
